// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - single-outstanding SDRAM port arbiter: boot loader, then two fixed-priority read clients
module sdram_port_arbiter #(
   parameter int MAX_R0_RUN = 4,
   parameter int RD_TIMEOUT = 1023,
   parameter int TO_W       = 10
) (
   input  logic        clk50,
   input  logic        reset_n,
   input  logic        ld_we,
   input  logic [24:0] ld_address,
   input  logic [15:0] ld_data,
   output logic        ld_op_begun,
   input  logic        ld_done,
   input  logic        ld_error,
   input  logic        r0_req,
   input  logic        r1_req,
   input  logic [24:0] r0_addr,
   input  logic [24:0] r1_addr,
   output logic        r0_ack,
   output logic        r1_ack,
   output logic [15:0] r0_rdata,
   output logic [15:0] r1_rdata,
   output logic        r0_rvalid,
   output logic        r1_rvalid,
   output logic        mem_req,
   output logic        mem_we,
   output logic [24:0] mem_address,
   output logic [15:0] mem_wdata,
   input  logic        mem_op_begun,
   input  logic [15:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        boot_done,
   output logic        rd_timeout
);

   localparam int RUN_W = $clog2(MAX_R0_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_R0_RUN);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(RD_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_BOOT, S_G_LD, S_IDLE, S_G_R0, S_G_R1, S_RD_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [24:0]       addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              owner_q, owner_d;
   logic              boot_done_q, boot_done_d;
   logic              rd_timeout_q, rd_timeout_d;
   logic [15:0]       r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
   logic              r0_rvalid_q, r0_rvalid_d, r1_rvalid_q, r1_rvalid_d;

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_BOOT;
         addr_q       <= '0;
         wdata_q      <= '0;
         run_q        <= '0;
         to_cnt_q     <= '0;
         owner_q      <= 1'b0;
         boot_done_q  <= 1'b0;
         rd_timeout_q <= 1'b0;
         r0_rdata_q   <= '0;
         r1_rdata_q   <= '0;
         r0_rvalid_q  <= 1'b0;
         r1_rvalid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         run_q        <= run_d;
         to_cnt_q     <= to_cnt_d;
         owner_q      <= owner_d;
         boot_done_q  <= boot_done_d;
         rd_timeout_q <= rd_timeout_d;
         r0_rdata_q   <= r0_rdata_d;
         r1_rdata_q   <= r1_rdata_d;
         r0_rvalid_q  <= r0_rvalid_d;
         r1_rvalid_q  <= r1_rvalid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      run_d        = run_q;
      to_cnt_d     = to_cnt_q;
      owner_d      = owner_q;
      boot_done_d  = boot_done_q;
      rd_timeout_d = rd_timeout_q;
      r0_rdata_d   = r0_rdata_q;
      r1_rdata_d   = r1_rdata_q;
      r0_rvalid_d  = 1'b0;
      r1_rvalid_d  = 1'b0;
      case (state_q)
         S_BOOT: begin
            // Loader completion wins over a simultaneous write request.
            if (ld_done || ld_error) begin
               boot_done_d = 1'b1;
               state_d     = S_IDLE;
            end else if (ld_we) begin
               addr_d  = ld_address;
               wdata_d = ld_data;
               state_d = S_G_LD;
            end
         end
         S_G_LD: begin
            if (mem_op_begun) state_d = S_BOOT;
         end
         S_IDLE: begin
            // Client 1 gets in when client 0 is idle or has used up its run.
            if (r1_req && (!r0_req || run_q == RUN_MAX)) begin
               addr_d  = r1_addr;
               run_d   = '0;
               state_d = S_G_R1;
            end else if (r0_req) begin
               addr_d  = r0_addr;
               if (run_q != RUN_MAX) run_d = run_q + RUN_W'(1);
               state_d = S_G_R0;
            end else begin
               run_d = '0;
            end
         end
         S_G_R0, S_G_R1: begin
            if (mem_op_begun) begin
               to_cnt_d = '0;
               owner_d  = (state_q == S_G_R1);
               state_d  = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (mem_rvalid) begin
               if (owner_q) begin
                  r1_rdata_d  = mem_rdata;
                  r1_rvalid_d = 1'b1;
               end else begin
                  r0_rdata_d  = mem_rdata;
                  r0_rvalid_d = 1'b1;
               end
               state_d = S_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
               if (to_cnt_q == TO_LAST) begin
                  rd_timeout_d = 1'b1;
                  state_d      = S_IDLE;
               end
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

   assign mem_req     = (state_q == S_G_LD) || (state_q == S_G_R0) || (state_q == S_G_R1);
   assign mem_we      = (state_q == S_G_LD);
   assign mem_address = addr_q;
   assign mem_wdata   = wdata_q;
   assign ld_op_begun = (state_q == S_G_LD) && mem_op_begun;
   assign r0_ack      = (state_q == S_G_R0) && mem_op_begun;
   assign r1_ack      = (state_q == S_G_R1) && mem_op_begun;
   assign r0_rdata    = r0_rdata_q;
   assign r1_rdata    = r1_rdata_q;
   assign r0_rvalid   = r0_rvalid_q;
   assign r1_rvalid   = r1_rvalid_q;
   assign boot_done   = boot_done_q;
   assign rd_timeout  = rd_timeout_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

   logic        clk50 = 1'b0;
   logic        reset_n = 1'b0;
   logic        ld_we = 1'b0, ld_done = 1'b0, ld_error = 1'b0;
   logic [24:0] ld_address = '0;
   logic [15:0] ld_data = '0;
   logic        ld_op_begun;
   logic        r0_req = 1'b0, r1_req = 1'b0;
   logic [24:0] r0_addr = '0, r1_addr = '0;
   logic        r0_ack, r1_ack, r0_rvalid, r1_rvalid;
   logic [15:0] r0_rdata, r1_rdata;
   logic        mem_req, mem_we, mem_op_begun, mem_rvalid;
   logic [24:0] mem_address;
   logic [15:0] mem_wdata, mem_rdata;
   logic        boot_done, rd_timeout;

   always #5 clk50 = ~clk50;

   sdram_port_arbiter dut (
      .clk50(clk50), .reset_n(reset_n),
      .ld_we(ld_we), .ld_address(ld_address), .ld_data(ld_data),
      .ld_op_begun(ld_op_begun), .ld_done(ld_done), .ld_error(ld_error),
      .r0_req(r0_req), .r1_req(r1_req), .r0_addr(r0_addr), .r1_addr(r1_addr),
      .r0_ack(r0_ack), .r1_ack(r1_ack), .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
      .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_op_begun(mem_op_begun), .mem_rdata(mem_rdata),
      .mem_rvalid(mem_rvalid), .boot_done(boot_done), .rd_timeout(rd_timeout)
   );

   typedef struct { logic we; logic [24:0] addr; logic [15:0] wd; int cl; } txn_t;
   typedef struct { int cl; logic [15:0] d; } rv_t;
   txn_t exp_txn[$];
   rv_t  exp_rv[$];
   int checks = 0, errors = 0;
   int txn_cnt = 0, rv_cnt = 0, ld_ack_cnt = 0;

   // Memory model: accepts after acc_dly cycles of mem_req, returns read data rv_dly cycles later.
   int   acc_dly = 0, rv_dly = 0, acc_cnt = 0, rd_cnt = 0;
   bit   withhold = 0, pend_rd = 0, addr_mode = 1;
   logic [15:0] fixed_data = '0, rsp_rdata = '0;
   logic rsp_ob = 1'b0, rsp_rv = 1'b0, man_rv = 1'b0;
   assign mem_op_begun = rsp_ob;
   assign mem_rvalid   = rsp_rv | man_rv;
   assign mem_rdata    = rsp_rdata;

   initial begin
      forever begin
         @(posedge clk50); #1;
         rsp_ob = 1'b0;
         rsp_rv = 1'b0;
         if (!reset_n) begin
            pend_rd = 0;
            acc_cnt = 0;
         end else if (pend_rd) begin
            if (rd_cnt == 0) begin
               if (!withhold) rsp_rv = 1'b1;
               pend_rd = 0;
            end else rd_cnt--;
         end else if (mem_req) begin
            if (acc_cnt == acc_dly) begin
               rsp_ob  = 1'b1;
               acc_cnt = 0;
               if (!mem_we) begin
                  pend_rd   = 1;
                  rd_cnt    = rv_dly;
                  rsp_rdata = addr_mode ? mem_address[15:0] : fixed_data;
               end
            end else acc_cnt++;
         end
      end
   end

   txn_t t;
   rv_t  r;
   always @(negedge clk50) begin
      if (reset_n) begin
         if (ld_op_begun) ld_ack_cnt++;
         if ((ld_op_begun || r0_ack || r1_ack) && !(mem_req && mem_op_begun)) begin
            errors++;
            $display("FAIL stray_ack: ld=%0b r0=%0b r1=%0b without accepted mem_req", ld_op_begun, r0_ack, r1_ack);
         end
         if (mem_req && mem_op_begun) begin
            txn_cnt++;
            checks++;
            if (exp_txn.size() == 0) begin
               errors++;
               $display("FAIL unexpected_txn: we=%0b addr=%h got, none expected", mem_we, mem_address);
            end else begin
               t = exp_txn.pop_front();
               if (mem_we !== t.we || mem_address !== t.addr || (t.we && mem_wdata !== t.wd) ||
                   ld_op_begun !== t.we || r0_ack !== (t.cl == 0) || r1_ack !== (t.cl == 1)) begin
                  errors++;
                  $display("FAIL txn: got we=%0b addr=%h wd=%h acks=%0b%0b%0b, expected we=%0b addr=%h wd=%h client=%0d",
                           mem_we, mem_address, mem_wdata, ld_op_begun, r0_ack, r1_ack, t.we, t.addr, t.wd, t.cl);
               end
            end
         end
         if (r0_rvalid || r1_rvalid) begin
            rv_cnt++;
            checks++;
            if (exp_rv.size() == 0 || (r0_rvalid && r1_rvalid)) begin
               errors++;
               $display("FAIL unexpected_rvalid: r0_rvalid=%0b r1_rvalid=%0b queue=%0d", r0_rvalid, r1_rvalid, exp_rv.size());
            end else begin
               r = exp_rv.pop_front();
               if ((r1_rvalid ? 1 : 0) != r.cl || (r1_rvalid ? r1_rdata : r0_rdata) !== r.d) begin
                  errors++;
                  $display("FAIL rvalid: got client=%0d data=%h, expected client=%0d data=%h",
                           r1_rvalid ? 1 : 0, r1_rvalid ? r1_rdata : r0_rdata, r.cl, r.d);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_txn(input logic we, input logic [24:0] a, input logic [15:0] d, input int cl);
      txn_t x;
      x.we = we; x.addr = a; x.wd = d; x.cl = cl;
      exp_txn.push_back(x);
   endtask

   task automatic push_rv(input int cl, input logic [15:0] d);
      rv_t x;
      x.cl = cl; x.d = d;
      exp_rv.push_back(x);
   endtask

   task automatic wait_txn(input int target);
      int n = 0;
      while (txn_cnt < target && n < 300) begin
         @(posedge clk50); #2;
         n++;
      end
      if (txn_cnt < target) chk("txn_wait_expired", 32'(txn_cnt), 32'(target));
   endtask

   task automatic wait_rv(input int target);
      int n = 0;
      while (rv_cnt < target && n < 300) begin
         @(posedge clk50); #2;
         n++;
      end
      if (rv_cnt < target) chk("rvalid_wait_expired", 32'(rv_cnt), 32'(target));
   endtask

   task automatic ld_write(input logic [24:0] a, input logic [15:0] d);
      int base = txn_cnt;
      push_txn(1'b1, a, d, 2);
      ld_address = a; ld_data = d; ld_we = 1'b1;
      wait_txn(base + 1);
      ld_we = 1'b0;
   endtask

   task automatic do_read(input int cl, input logic [24:0] a, input bit exp_data);
      int tb_ = txn_cnt;
      int rb  = rv_cnt;
      push_txn(1'b0, a, 16'h0, cl);
      if (exp_data) push_rv(cl, a[15:0]);
      if (cl == 0) begin r0_addr = a; r0_req = 1'b1; end
      else begin r1_addr = a; r1_req = 1'b1; end
      wait_txn(tb_ + 1);
      r0_req = 1'b0; r1_req = 1'b0;
      if (exp_data) wait_rv(rb + 1);
      repeat (2) @(posedge clk50);
      #2;
   endtask

   initial begin
      int base, rb, n, cnt;
      #3;
      chk("reset_ctrl_outs", 32'({mem_req, mem_we, ld_op_begun, r0_ack, r1_ack, r0_rvalid, r1_rvalid, boot_done, rd_timeout}), 32'h0);
      chk("reset_data_outs", 32'({r0_rdata, r1_rdata} | 32'(mem_address) | 32'(mem_wdata)), 32'h0);
      repeat (2) @(posedge clk50);
      #1 reset_n = 1'b1;

      // Boot writes with r0 held pending
      acc_dly = 2;
      r0_addr = 25'h100; r0_req = 1'b1;
      ld_write(25'h0, 16'hA5A5);
      ld_write(25'h1, 16'h1234);
      ld_write(25'h2, 16'hBEEF);
      chk("boot_ld_acks", 32'(ld_ack_cnt), 32'd3);
      chk("boot_done_during_boot", 32'(boot_done), 32'd0);

      // Boot exit, then the pending r0 read
      acc_dly = 0; addr_mode = 0; fixed_data = 16'h55AA;
      push_txn(1'b0, 25'h100, 16'h0, 0);
      push_rv(0, 16'h55AA);
      base = txn_cnt; rb = rv_cnt;
      @(posedge clk50); #1 ld_done = 1'b1;
      @(posedge clk50); #1 ld_done = 1'b0;
      chk("boot_done_set", 32'(boot_done), 32'd1);
      chk("idle_no_mem_req", 32'(mem_req), 32'd0);
      @(posedge clk50); #1;
      chk("grant_latency", 32'({mem_req, mem_we}), 32'h2);
      wait_txn(base + 1);
      r0_req = 1'b0;
      wait_rv(rb + 1);
      chk("r0_rdata_boot_exit", 32'(r0_rdata), 32'h55AA);
      ld_address = 25'h5; ld_we = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk50); #1;
         if (mem_req) cnt++;
      end
      ld_we = 1'b0;
      chk("ld_we_after_boot", 32'(cnt), 32'd0);
      repeat (2) @(posedge clk50);
      #2;

      // Fairness: both clients held
      addr_mode = 1;
      r0_addr = 25'h30; r1_addr = 25'h40;
      for (int i = 0; i < 10; i++) begin
         if (i == 4 || i == 9) begin push_txn(1'b0, 25'h40, 16'h0, 1); push_rv(1, 16'h0040); end
         else begin push_txn(1'b0, 25'h30, 16'h0, 0); push_rv(0, 16'h0030); end
      end
      base = txn_cnt; rb = rv_cnt;
      r0_req = 1'b1; r1_req = 1'b1;
      wait_txn(base + 10);
      r0_req = 1'b0; r1_req = 1'b0;
      wait_rv(rb + 10);
      repeat (2) @(posedge clk50);
      #2;

      // r0 alone is never cut off by the run limit
      for (int i = 0; i < 6; i++) begin push_txn(1'b0, 25'h30, 16'h0, 0); push_rv(0, 16'h0030); end
      base = txn_cnt; rb = rv_cnt;
      r0_req = 1'b1;
      wait_txn(base + 6);
      r0_req = 1'b0;
      wait_rv(rb + 6);
      repeat (2) @(posedge clk50);
      #2;

      // Data steering
      do_read(0, 25'h10, 1);
      do_read(1, 25'h20, 1);
      chk("r0_rdata_steer", 32'(r0_rdata), 32'h0010);
      chk("r1_rdata_steer", 32'(r1_rdata), 32'h0020);

      // Timeout on r1, then a stray rvalid in IDLE, then a normal r0 read
      withhold = 1;
      base = txn_cnt;
      push_txn(1'b0, 25'h55, 16'h0, 1);
      r1_addr = 25'h55; r1_req = 1'b1;
      wait_txn(base + 1);
      r1_req = 1'b0;
      n = 0;
      while (!rd_timeout && n < 2000) begin
         @(posedge clk50); #2;
         n++;
      end
      chk("timeout_cycles", 32'(n), 32'd1023);
      withhold = 0;
      man_rv = 1'b1;
      @(posedge clk50); #1 man_rv = 1'b0;
      repeat (3) @(posedge clk50);
      #2;
      chk("r1_rdata_after_timeout", 32'(r1_rdata), 32'h0020);
      do_read(0, 25'h77, 1);
      chk("r0_rdata_after_timeout", 32'(r0_rdata), 32'h0077);
      chk("rd_timeout_sticky", 32'(rd_timeout), 32'd1);

      // Reset while in RD_WAIT
      withhold = 1;
      base = txn_cnt;
      push_txn(1'b0, 25'h99, 16'h0, 0);
      r0_addr = 25'h99; r0_req = 1'b1;
      wait_txn(base + 1);
      repeat (2) @(posedge clk50);
      #3 reset_n = 1'b0;
      #1;
      chk("async_reset_ctrl", 32'({mem_req, mem_we, ld_op_begun, r0_ack, r1_ack, r0_rvalid, r1_rvalid, boot_done, rd_timeout}), 32'h0);
      chk("async_reset_data", 32'({r0_rdata, r1_rdata} | 32'(mem_address)), 32'h0);
      withhold = 0;
      @(posedge clk50); #1 reset_n = 1'b1;
      man_rv = 1'b1;
      @(posedge clk50); #1 man_rv = 1'b0;
      repeat (3) @(posedge clk50);
      #2;
      chk("post_reset_boot_done", 32'(boot_done), 32'd0);
      r0_req = 1'b0;
      ld_write(25'h3, 16'hCAFE);
      repeat (3) @(posedge clk50);
      #2;

      chk("txn_queue_drained", 32'(exp_txn.size()), 32'd0);
      chk("rv_queue_drained", 32'(exp_rv.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
